// File: rtl/cache_mem_pkg.sv
// Shared definitions for the line-burst memory: FSM state encoding and
// default parameter values used by line_burst_memory and mem_word_array.
package cache_mem_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WR_LAT     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are never reset.
//   CLK       clock, rising edge
//   we        write enable
//   wr_addr   write word address
//   wr_data   write data
//   rd_addr   read word address
//   rd_data_c read data (combinational)
module mem_word_array #(
  parameter int unsigned ADDR_W = cache_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_mem_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write
  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/line_burst_memory.sv
// Cache-line backing memory: a read fills a whole aligned line one word per
// cycle into DataOutMem; a write stores one word with a fixed completion latency.
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   Address    word address of the request
//   DataIn     write data
//   MemRead    line-fill request (wins over MemWrite)
//   MemWrite   single-word write request
//   Ready      one-cycle completion pulse
//   Busy       operation in progress; requests ignored
//   DataOutMem assembled line, word k in [k*DATA_W +: DATA_W]
module line_burst_memory #(
  parameter int unsigned ADDR_W     = cache_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = cache_mem_pkg::DATA_W,
  parameter int unsigned LINE_WORDS = cache_mem_pkg::LINE_WORDS,
  parameter int unsigned WR_LAT     = cache_mem_pkg::WR_LAT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR_W-1:0]            Address,
  input  logic [DATA_W-1:0]            DataIn,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  output logic                         Ready,
  output logic                         Busy,
  output logic [LINE_WORDS*DATA_W-1:0] DataOutMem
);

  import cache_mem_pkg::*;

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned LAT_W = $clog2(WR_LAT + 1);
  localparam int unsigned CNT_W = (OFF_W > LAT_W) ? OFF_W : LAT_W;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_d, busy_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept_rd_c, accept_wr_c, load_c, mem_we_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;

  // Read address walks the aligned line: base high bits, counter as word offset
  assign rd_addr_c = {addr_q[ADDR_W-1:OFF_W], cnt_q[OFF_W-1:0]};

  mem_word_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .CLK      (CLK),
    .we       (mem_we_c),
    .wr_addr  (addr_q),
    .wr_data  (wdata_q),
    .rd_addr  (rd_addr_c),
    .rd_data_c(rd_data_c)
  );

  // State, counter, handshake and request latches
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Ready   <= ready_d;
      Busy    <= busy_d;
      if (accept_rd_c) begin
        addr_q <= {Address[ADDR_W-1:OFF_W], OFF_W'(0)};
      end else if (accept_wr_c) begin
        addr_q  <= Address;
        wdata_q <= DataIn;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    busy_d      = Busy;
    accept_rd_c = 1'b0;
    accept_wr_c = 1'b0;
    load_c      = 1'b0;
    mem_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead) begin
          accept_rd_c = 1'b1;
          state_d     = READ;
          cnt_d       = '0;
          busy_d      = 1'b1;
        end else if (MemWrite) begin
          accept_wr_c = 1'b1;
          state_d     = WRITE;
          cnt_d       = '0;
          busy_d      = 1'b1;
        end
      end
      READ: begin
        load_c = 1'b1;
        if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        // Array write lands on the first edge after accept
        mem_we_c = (cnt_q == '0);
        if (cnt_q == CNT_W'(WR_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Line assembly: only the slice selected by the counter is refilled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DataOutMem <= '0;
    end else if (load_c) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        if (cnt_q[OFF_W-1:0] == OFF_W'(k)) DataOutMem[k*DATA_W +: DATA_W] <= rd_data_c;
      end
    end
  end

endmodule

// File: tb/tb_line_burst_memory.sv
// Directed bench for line_burst_memory: default configuration (4x32, WR_LAT 4)
// and an 8x16 line with WR_LAT 2.
module tb_line_burst_memory;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;

  logic [9:0]   a_addr = '0;
  logic [31:0]  a_din  = '0;
  logic         a_rd = 1'b0, a_wr = 1'b0;
  logic         a_ready, a_busy;
  logic [127:0] a_data;

  logic [9:0]   b_addr = '0;
  logic [15:0]  b_din  = '0;
  logic         b_rd = 1'b0, b_wr = 1'b0;
  logic         b_ready, b_busy;
  logic [127:0] b_data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  line_burst_memory u_dut_a (
    .CLK(CLK), .RST(RST), .Address(a_addr), .DataIn(a_din),
    .MemRead(a_rd), .MemWrite(a_wr), .Ready(a_ready), .Busy(a_busy),
    .DataOutMem(a_data)
  );

  line_burst_memory #(.ADDR_W(10), .DATA_W(16), .LINE_WORDS(8), .WR_LAT(2)) u_dut_b (
    .CLK(CLK), .RST(RST), .Address(b_addr), .DataIn(b_din),
    .MemRead(b_rd), .MemWrite(b_wr), .Ready(b_ready), .Busy(b_busy),
    .DataOutMem(b_data)
  );

  // One request on DUT A, then observe 16 edges (edge 0 = accept)
  task automatic run_a(input logic rd, input logic wr, input logic [9:0] addr,
                       input logic [31:0] din, output int rdy_edge, output int rdy_cnt,
                       output int busy_cnt, output int overlap);
    @(negedge CLK);
    a_rd = rd; a_wr = wr; a_addr = addr; a_din = din;
    rdy_edge = -1; rdy_cnt = 0; busy_cnt = 0; overlap = 0;
    for (int e = 0; e < 16; e++) begin
      @(posedge CLK); #1;
      if (e == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
      if (a_ready) begin rdy_cnt++; if (rdy_edge < 0) rdy_edge = e; end
      if (a_busy) busy_cnt++;
      if (a_busy && a_ready) overlap++;
    end
  endtask

  task automatic run_b(input logic rd, input logic wr, input logic [9:0] addr,
                       input logic [15:0] din, output int rdy_edge, output int rdy_cnt,
                       output int busy_cnt, output int overlap);
    @(negedge CLK);
    b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
    rdy_edge = -1; rdy_cnt = 0; busy_cnt = 0; overlap = 0;
    for (int e = 0; e < 16; e++) begin
      @(posedge CLK); #1;
      if (e == 0) begin b_rd = 1'b0; b_wr = 1'b0; end
      if (b_ready) begin rdy_cnt++; if (rdy_edge < 0) rdy_edge = e; end
      if (b_busy) busy_cnt++;
      if (b_busy && b_ready) overlap++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", a_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_data !== 128'd0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data); end
    checks++; if (b_data !== 128'd0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b: data %h busy %b want 0/0", b_data, b_busy); end
    // First accept on the first edge after release
    @(negedge CLK);
    RST = 1'b1; a_rd = 1'b1; a_addr = 10'h000;
    @(posedge CLK); #1;
    a_rd = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL first_accept_busy: got %b want 1", a_busy); end
    repeat (6) @(posedge CLK);
  endtask

  task automatic test_read_burst();
    int re, rc, bc, ov;
    for (int k = 0; k < 4; k++) begin
      run_a(1'b0, 1'b1, 10'h010 + 10'(k), 32'hA0 + 32'(k), re, rc, bc, ov);
      checks++; if (re !== 4 || rc !== 1 || bc !== 4) begin errors++; $display("FAIL preload_write%0d: ready edge %0d cnt %0d busy %0d want 4/1/4", k, re, rc, bc); end
    end
    run_a(1'b1, 1'b0, 10'h012, 32'h0, re, rc, bc, ov);
    checks++; if (re !== 4) begin errors++; $display("FAIL read_ready_edge: got %0d want 4", re); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL read_ready_count: got %0d want 1", rc); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL read_busy_cycles: got %0d want 4", bc); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL read_busy_ready_overlap: got %0d want 0", ov); end
    checks++; if (a_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin errors++; $display("FAIL read_line: got %h want 000000a3000000a2000000a1000000a0", a_data); end
  endtask

  task automatic test_write_then_read();
    int re, rc, bc, ov;
    run_a(1'b0, 1'b1, 10'h3F5, 32'hDEADBEEF, re, rc, bc, ov);
    checks++; if (re !== 4 || rc !== 1) begin errors++; $display("FAIL write_ready: edge %0d cnt %0d want 4/1", re, rc); end
    checks++; if (a_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin errors++; $display("FAIL write_keeps_line: got %h", a_data); end
    run_a(1'b1, 1'b0, 10'h3F4, 32'h0, re, rc, bc, ov);
    checks++; if (a_data[32 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_readback: got %h want deadbeef", a_data[32 +: 32]); end
  endtask

  task automatic test_both_high();
    int re, rc, bc, ov;
    run_a(1'b0, 1'b1, 10'h020, 32'h11112222, re, rc, bc, ov);
    run_a(1'b1, 1'b1, 10'h020, 32'h99999999, re, rc, bc, ov);
    checks++; if (re !== 4 || rc !== 1) begin errors++; $display("FAIL both_ready: edge %0d cnt %0d want 4/1", re, rc); end
    checks++; if (a_data[31:0] !== 32'h11112222) begin errors++; $display("FAIL both_read_data: got %h want 11112222", a_data[31:0]); end
    run_a(1'b1, 1'b0, 10'h020, 32'h0, re, rc, bc, ov);
    checks++; if (a_data[31:0] !== 32'h11112222) begin errors++; $display("FAIL both_write_dropped: got %h want 11112222", a_data[31:0]); end
  endtask

  task automatic test_busy_ignore();
    int re, rc, bc, ov;
    int rdy;
    run_a(1'b0, 1'b1, 10'h030, 32'h33333333, re, rc, bc, ov);
    @(negedge CLK);
    a_rd = 1'b1; a_addr = 10'h030; rdy = 0;
    for (int e = 0; e < 16; e++) begin
      @(posedge CLK); #1;
      if (e == 0) a_rd = 1'b0;
      if (e == 1) begin a_wr = 1'b1; a_din = 32'h55555555; end
      if (e == 2) a_wr = 1'b0;
      if (a_ready) rdy++;
    end
    checks++; if (rdy !== 1) begin errors++; $display("FAIL busy_ignore_ready_count: got %0d want 1", rdy); end
    run_a(1'b1, 1'b0, 10'h030, 32'h0, re, rc, bc, ov);
    checks++; if (a_data[31:0] !== 32'h33333333) begin errors++; $display("FAIL busy_ignore_array: got %h want 33333333", a_data[31:0]); end
  endtask

  task automatic test_reset_mid();
    int re, rc, bc, ov;
    int rdy;
    @(negedge CLK);
    a_rd = 1'b1; a_addr = 10'h010; rdy = 0;
    @(posedge CLK); #1; a_rd = 1'b0;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    #1;
    checks++; if (a_data !== 128'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_read: data %h busy %b want 0/0", a_data, a_busy); end
    repeat (2) begin @(posedge CLK); #1; if (a_ready) rdy++; end
    @(negedge CLK); RST = 1'b1;
    repeat (6) begin @(posedge CLK); #1; if (a_ready) rdy++; end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL reset_mid_read_ready: got %0d pulses want 0", rdy); end
    run_a(1'b1, 1'b0, 10'h010, 32'h0, re, rc, bc, ov);
    checks++; if (re !== 4 || a_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin errors++; $display("FAIL read_after_reset: edge %0d data %h want 4", re, a_data); end
    // Reset before the write edge suppresses the write
    run_a(1'b0, 1'b1, 10'h040, 32'h12345678, re, rc, bc, ov);
    @(negedge CLK); a_wr = 1'b1; a_addr = 10'h040; a_din = 32'h0BADF00D;
    @(posedge CLK); #1; a_wr = 1'b0;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    // Reset after the write edge keeps the word
    @(negedge CLK); a_wr = 1'b1; a_addr = 10'h041; a_din = 32'hCAFE0001;
    @(posedge CLK); #1; a_wr = 1'b0;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    run_a(1'b1, 1'b0, 10'h040, 32'h0, re, rc, bc, ov);
    checks++; if (a_data[31:0] !== 32'h12345678) begin errors++; $display("FAIL reset_before_write_edge: got %h want 12345678", a_data[31:0]); end
    checks++; if (a_data[32 +: 32] !== 32'hCAFE0001) begin errors++; $display("FAIL reset_after_write_edge: got %h want cafe0001", a_data[32 +: 32]); end
  endtask

  task automatic test_back_to_back();
    int first, second, busy5;
    for (int op = 0; op < 2; op++) begin
      @(negedge CLK);
      if (op == 0) a_rd = 1'b1; else a_wr = 1'b1;
      a_addr = 10'h010; a_din = 32'h000000A0;
      first = -1; second = -1; busy5 = 0;
      for (int e = 0; e < 16; e++) begin
        @(posedge CLK); #1;
        if (e == 5) begin a_rd = 1'b0; a_wr = 1'b0; busy5 = int'(a_busy); end
        if (a_ready) begin if (first < 0) first = e; else if (second < 0) second = e; end
      end
      checks++; if (first !== 4 || second !== 9 || busy5 !== 1) begin errors++; $display("FAIL back_to_back_op%0d: ready edges %0d,%0d busy@5 %0d want 4,9,1", op, first, second, busy5); end
    end
  endtask

  task automatic test_config8();
    int re, rc, bc, ov;
    logic [127:0] exp_line;
    for (int k = 0; k < 8; k++) begin
      run_b(1'b0, 1'b1, 10'h080 + 10'(k), 16'h1000 + 16'(k), re, rc, bc, ov);
      exp_line[k*16 +: 16] = 16'h1000 + 16'(k);
      checks++; if (re !== 2 || rc !== 1 || bc !== 2) begin errors++; $display("FAIL cfg8_write%0d: ready edge %0d cnt %0d busy %0d want 2/1/2", k, re, rc, bc); end
    end
    run_b(1'b1, 1'b0, 10'h085, 16'h0, re, rc, bc, ov);
    checks++; if (re !== 8 || rc !== 1 || bc !== 8 || ov !== 0) begin errors++; $display("FAIL cfg8_read_timing: edge %0d cnt %0d busy %0d overlap %0d want 8/1/8/0", re, rc, bc, ov); end
    checks++; if (b_data !== exp_line) begin errors++; $display("FAIL cfg8_read_line: got %h want %h", b_data, exp_line); end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_then_read();
    test_both_high();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_config8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_memory.md
LINE_BURST_MEMORY -- requirements
Module: line_burst_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; the array depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, bits per word.
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per cache line; legal values are powers of 2, 2..16.
REQ-004 SHALL have parameter WR_LAT, default 4, cycles from write accept to Ready; legal values are 2..15.
REQ-005 SHALL have port CLK  in  1  clock, rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Address  in  ADDR_W  word address of the request.
REQ-008 SHALL have port DataIn  in  DATA_W  write data.
REQ-009 SHALL have port MemRead  in  1  line-fill request.
REQ-010 SHALL have port MemWrite  in  1  single-word write request.
REQ-011 SHALL have port Ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port Busy  out  1  operation in progress; new requests are ignored.
REQ-013 SHALL have port DataOutMem  out  LINE_WORDS*DATA_W  assembled line, word k in slice [k*DATA_W +: DATA_W].

Function
REQ-014 SHALL implement an FSM with states IDLE, READ, WRITE; the word counter width is clog2(LINE_WORDS) for READ and clog2(WR_LAT+1) for WRITE, and both share one register.
REQ-015 In IDLE, a request SHALL be accepted on the rising edge where MemRead or MemWrite is high; that edge is edge 0.
REQ-016 If MemRead and MemWrite are both high at accept, the read SHALL win and the write SHALL be dropped.
REQ-017 Read accept SHALL latch base = Address with its low clog2(LINE_WORDS) bits forced to 0, then enter READ with counter = 0.
REQ-018 In READ, at edge k+1 (k = 0..LINE_WORDS-1), slice k of DataOutMem SHALL be loaded from array[base+k]; there is no wrap beyond the line.
REQ-019 At edge LINE_WORDS, Ready SHALL go 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-020 Write accept SHALL latch Address and DataIn; array[Address] SHALL be written at edge 1.
REQ-021 Ready SHALL pulse for one cycle at edge WR_LAT, and the FSM SHALL then return to IDLE.
REQ-022 Busy SHALL be 1 from edge 0 until the edge at which Ready rises; Busy and Ready are never both 1.
REQ-023 MemRead and MemWrite SHALL be ignored while Busy=1; requesters must hold or re-issue the request.
REQ-024 A request present in the cycle Ready=1 SHALL be accepted on the next edge (back-to-back), giving minimum spacing LINE_WORDS+1 cycles for reads and WR_LAT+1 cycles for writes.
REQ-025 Slices not yet refilled in a burst SHALL hold their previous values; DataOutMem is valid only when Ready=1 and SHALL hold until the next read's edge 1.
REQ-026 Writes SHALL NOT alter DataOutMem.
REQ-027 A read accepted after a write's Ready pulse SHALL return the written data.

Reset
REQ-028 On RST low, the module SHALL go to IDLE asynchronously with Ready=0, Busy=0, DataOutMem=0 and counter=0.
REQ-029 The array SHALL NOT be reset; its contents are retained across RST.
REQ-030 Reset mid-READ SHALL abort the burst with no Ready pulse.
REQ-031 Reset mid-WRITE before edge 1 SHALL suppress the array write; reset at or after edge 1 SHALL leave the word written.
REQ-032 The first accept SHALL be possible on the first rising edge after RST deasserts.

Structure
REQ-033 A shared package cache_mem_pkg SHALL hold the FSM state enum (IDLE/READ/WRITE) and the default parameter constants ADDR_W, DATA_W, LINE_WORDS and WR_LAT.
REQ-034 The storage SHALL be a sub-module mem_word_array (1 read port, 1 write port, synchronous write, combinational read); the FSM and line assembly stay in line_burst_memory.

Verification
REQ-035 Preload array[0x10..0x13] = 0xA0..0xA3, MemRead with Address=0x12 -> slices 0..3 = 0xA0..0xA3, Ready pulses at edge 4, Busy high for edges 0..3.
REQ-036 MemWrite with Address=0x3F5 and DataIn=0xDEADBEEF, then MemRead with Address=0x3F4 -> Ready at write edge 4, and slice 1 = 0xDEADBEEF.
REQ-037 MemRead and MemWrite both high at Address=0x20 -> read burst only, and array[0x20] is unchanged.
REQ-038 MemWrite pulsed at edge 2 of a read burst -> ignored: no array change and a single Ready pulse.
REQ-039 RST low at edge 2 of a read -> Ready never pulses and DataOutMem = 0; a new read accepted right after reset completes normally.
REQ-040 LINE_WORDS=8, DATA_W=16, WR_LAT=2 -> the 8-word burst fills a 128-bit line with Ready at edge 8, and the write Ready arrives at edge 2.
